sram_rd_streamer: RTL and testbench
===================================

SRAM_RD_STREAMER -- requirements
Module: sram_rd_streamer

Interface
REQ-001: Parameter DATA_W, default 128, SRAM word width in bits.
REQ-002: Parameter ADDR_W, default 11, SRAM address width in bits (2048 words).
REQ-003: Parameter FIFO_DEPTH, default 4, output buffer entries; power of two, at least 2.
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: reset_n  input  1  asynchronous, active-low reset.
REQ-006: start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007: base_addr  input  ADDR_W  first SRAM word address, captured with start.
REQ-008: len  input  ADDR_W+1  burst length in words (0..2048), captured with start.
REQ-009: busy  output  1  high from the cycle after an accepted start until done.
REQ-010: done  output  1  one-cycle pulse after the last word leaves out_data.
REQ-011: sram_cen  output  1  SRAM chip enable, active low.
REQ-012: sram_wen  output  1  SRAM write enable, active low; tied high, so the block only reads.
REQ-013: sram_a  output  ADDR_W  SRAM address.
REQ-014: sram_q  input  DATA_W  SRAM read data; valid in the cycle after the read-issue edge.
REQ-015: out_valid  output  1  out_data holds a valid word.
REQ-016: out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-017: out_data  output  DATA_W  head-of-FIFO word.

Function
REQ-018: The FSM SHALL use three states: IDLE, RUN, DRAIN.
REQ-019: In IDLE with start=1 and len>0, the block SHALL capture base_addr and len and enter RUN.
REQ-020: In IDLE with start=1 and len=0, the block SHALL stay in IDLE, issue no reads, and pulse done in the next cycle.
REQ-021: In RUN, a read SHALL issue (sram_cen=0, sram_a=current address) only when words remaining > 0 and FIFO occupancy + in-flight count < FIFO_DEPTH.
REQ-022: sram_cen SHALL be 1 in every cycle with no read issue.
REQ-023: The address SHALL increment by 1 per issued read and wrap from 2^ADDR_W-1 to 0.
REQ-024: A word issued at edge N SHALL be written into the FIFO at edge N+1; in-flight count is at most 1.
REQ-025: The FSM SHALL go from RUN to DRAIN on the edge that issues the final read.
REQ-026: The FSM SHALL go from DRAIN to IDLE, with done=1 for one cycle, once the FIFO is empty and nothing is in flight.
REQ-027: FIFO push and pop SHALL be allowed in the same cycle; occupancy is then unchanged and ordering is preserved.
REQ-028: out_valid SHALL equal FIFO not-empty, and out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-029: Throughput SHALL be one word per cycle with out_ready held high; first out_valid SHALL occur 2 cycles after start.
REQ-030: start while busy=1 SHALL be ignored.
REQ-031: The FIFO SHALL never overflow, since issue is credit-gated, and never underflow, since pop requires out_valid.

Reset
REQ-032: While reset_n=0, the block SHALL hold: state=IDLE, busy=0, done=0, out_valid=0, sram_cen=1, sram_a=0, FIFO empty, in-flight cleared, counters 0.
REQ-033: A reset mid-burst SHALL discard all buffered and in-flight words; no done pulse follows.
REQ-034: sram_wen SHALL be 1 in reset and in every other state.

Structure
REQ-035: A shared package SHALL hold the state encoding and the default DATA_W, ADDR_W and FIFO_DEPTH constants.
REQ-036: The output buffer SHALL be one sub-module, sync_fifo (parameterised width and depth, with full, empty and count).

Verification
REQ-037: base_addr=0x010, len=4, out_ready=1 -> reads to 0x010..0x013 on consecutive cycles, out_valid 2 cycles after start, 4 beats in order, done 1 cycle after last beat.
REQ-038: base_addr=0x7FE, len=4 -> sram_a sequence 0x7FE, 0x7FF, 0x000, 0x001.
REQ-039: len=8, out_ready=0 for 10 cycles then 1 -> exactly 4 reads issued during the stall, out_data stable, all 8 words delivered without loss or duplication.
REQ-040: len=0 -> no sram_cen=0 cycle, done pulses the cycle after start, busy stays 0.
REQ-041: len=2048 with random out_ready -> every address read exactly once, 2048 beats, done once.
REQ-042: reset_n low during RUN of a len=16 burst -> outputs at reset values immediately; a following len=2 burst completes normally.

Source files
------------

// File: rtl/sram_rd_streamer_pkg.sv
// Shared types and default geometry for the SRAM read streamer.
package sram_rd_streamer_pkg;

  localparam int unsigned DEF_DATA_W     = 128;
  localparam int unsigned DEF_ADDR_W     = 11;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sram_rd_streamer_if.sv
// SRAM port plus output stream of the read streamer; master is the streamer side.
interface sram_rd_streamer_if
  import sram_rd_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              sram_cen;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output sram_cen, sram_wen, sram_a, out_valid, out_data,
    input  sram_q, out_ready
  );

  modport slave (
    input  sram_cen, sram_wen, sram_a, out_valid, out_data,
    output sram_q, out_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; simultaneous push/pop keeps occupancy.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sram_rd_streamer.sv
// Streams a contiguous, address-wrapping SRAM burst into a credit-gated output FIFO.
module sram_rd_streamer
  import sram_rd_streamer_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  sram_rd_streamer_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              in_flight;
  logic              issue;
  logic              credit_ok;
  logic              pop;
  logic              drain_done;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // A read may only start if its word is guaranteed a FIFO slot two edges later.
  assign credit_ok  = (32'(fifo_count) + 32'(in_flight)) < FIFO_DEPTH;
  assign issue      = (state == RUN) && (remaining != '0) && credit_ok && !fifo_full;
  assign pop        = bus.out_valid && bus.out_ready;
  assign drain_done = !in_flight && (fifo_empty || (fifo_count == CNT_W'(1) && pop));

  assign bus.sram_cen  = ~issue;
  assign bus.sram_wen  = 1'b1;
  assign bus.sram_a    = addr;
  assign bus.out_valid = ~fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      in_flight <= 1'b0;
    end else begin
      done      <= 1'b0;
      in_flight <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              addr      <= base_addr;
              remaining <= len;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W + 1)'(1);
            if (remaining == (ADDR_W + 1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish on the edge that consumes the last buffered word.
          if (drain_done) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_flight),
    .push_data (bus.sram_q),
    .pop       (pop),
    .pop_data  (bus.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Randomised bench for sram_rd_streamer against a cycle-level burst/credit model.
module tb_sram_rd_streamer;

  localparam int unsigned DW     = 128;
  localparam int unsigned AW     = 11;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NWORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy;
  logic          done;

  sram_rd_streamer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  sram_rd_streamer #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [NWORDS];

  // Synchronous SRAM: data for the address sampled at an edge appears after it; junk otherwise.
  always @(posedge clk) begin
    if (!bus.sram_cen) bus.sram_q <= mem[bus.sram_a];
    else               bus.sram_q <= {$urandom, $urandom, $urandom, $urandom};
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  int unsigned   cyc = 0;
  bit            m_busy = 0;
  bit            done_due = 0;
  int unsigned   reads_left = 0, issued = 0, consumed = 0, arrived = 0, len_total = 0;
  logic [AW-1:0] next_addr = '0, m_base = '0, ha;
  int unsigned   arr_q[$];
  int unsigned   tmp;
  bit            exp_cen, exp_valid, idle_now, prev_hold = 0, prev_valid_obs = 0;
  logic [DW-1:0] prev_data;

  // Observation log (never cleared; tests take snapshots)
  int unsigned   n_reads = 0, n_beats = 0, n_done = 0, n_busy = 0;
  int unsigned   rise_cyc = 0, last_beat_cyc = 0, done_cyc = 0;
  logic [AW-1:0] addr_log[$];
  int unsigned   rd_cyc_log[$];
  int unsigned   rd_hits[NWORDS];

  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_out_valid", bus.out_valid, 1'b0);
      check("reset_sram_cen", bus.sram_cen, 1'b1);
      check("reset_sram_wen", bus.sram_wen, 1'b1);
      check("reset_sram_a", bus.sram_a, '0);
      m_busy = 0; done_due = 0; reads_left = 0; issued = 0; consumed = 0;
      arrived = 0; arr_q.delete(); prev_hold = 0; prev_valid_obs = 0;
    end else begin
      while (arr_q.size() > 0 && arr_q[0] <= cyc) begin
        tmp = arr_q.pop_front();
        arrived++;
      end
      exp_cen   = !(m_busy && reads_left > 0 && (issued - consumed) < DEPTH);
      exp_valid = arrived > consumed;
      ha        = m_base + AW'(consumed);

      check("sram_cen", bus.sram_cen, exp_cen);
      check("sram_wen", bus.sram_wen, 1'b1);
      check("out_valid", bus.out_valid, exp_valid);
      check("busy", busy, m_busy);
      check("done", done, done_due);
      if (!exp_cen)  check("sram_a", bus.sram_a, next_addr);
      if (exp_valid) check("out_data", bus.out_data, mem[ha]);
      if (prev_hold) check("out_data_stable", bus.out_data, prev_data);

      if (!bus.sram_cen) begin
        n_reads++;
        addr_log.push_back(bus.sram_a);
        rd_cyc_log.push_back(cyc);
        rd_hits[bus.sram_a]++;
      end
      if (bus.out_valid && !prev_valid_obs) rise_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin n_beats++; last_beat_cyc = cyc; end
      if (done) begin n_done++; done_cyc = cyc; end
      if (busy) n_busy++;
      prev_valid_obs = bus.out_valid;

      prev_hold = exp_valid && !bus.out_ready;
      prev_data = bus.out_data;
      idle_now  = !m_busy;
      done_due  = 0;
      if (!exp_cen) begin
        issued++;
        reads_left--;
        next_addr = next_addr + AW'(1);
        arr_q.push_back(cyc + 2);
      end
      if (exp_valid && bus.out_ready) begin
        consumed++;
        if (consumed == len_total) begin
          done_due = 1;
          m_busy   = 0;
        end
      end
      if (start && idle_now) begin
        if (len == '0) done_due = 1;
        else begin
          m_busy = 1; reads_left = len; len_total = len;
          next_addr = base_addr; m_base = base_addr;
          issued = 0; consumed = 0; arrived = 0; arr_q.delete();
        end
      end
    end
    cyc++;
  end

  bit          rand_ready = 0;
  int unsigned s_cyc, s_reads, s_beats, s_done, s_busy, s_log;
  int unsigned hits_base[NWORDS];
  logic [AW-1:0] exp1 [4] = '{11'h010, 11'h011, 11'h012, 11'h013};
  logic [AW-1:0] exp2 [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic snap();
    s_reads = n_reads; s_beats = n_beats; s_done = n_done; s_busy = n_busy;
    s_log = addr_log.size();
  endtask

  task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l);
    base_addr = b; len = l; start = 1'b1;
    s_cyc = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned k = 0;
    while (n_done == s_done && k < budget) begin step(1); k++; end
    check("done_timeout", n_done != s_done, 1'b1);
    step(2);
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
      rd_hits[i] = 0;
    end
    bus.out_ready = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(2);

    // Basic burst, consumer always ready
    bus.out_ready = 1'b1;
    snap();
    start_burst(11'h010, 12'd4);
    wait_done(100);
    check("t1_reads", n_reads - s_reads, 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", addr_log[s_log + i], exp1[i]);
      check("t1_read_cycle", rd_cyc_log[s_log + i], s_cyc + 1 + i);
    end
    check("t1_valid_latency", rise_cyc - s_cyc - 1, 2);
    check("t1_beats", n_beats - s_beats, 4);
    check("t1_done_gap", done_cyc - last_beat_cyc, 1);

    // Address wrap
    snap();
    start_burst(11'h7FE, 12'd4);
    wait_done(100);
    check("t2_reads", n_reads - s_reads, 4);
    for (int i = 0; i < 4; i++) check("t2_addr", addr_log[s_log + i], exp2[i]);

    // Consumer stall: credit limit stops issue at FIFO depth
    bus.out_ready = 1'b0;
    snap();
    start_burst(AW'($urandom), 12'd8);
    step(9);
    check("t3_stall_reads", n_reads - s_reads, 4);
    bus.out_ready = 1'b1;
    wait_done(100);
    check("t3_reads", n_reads - s_reads, 8);
    check("t3_beats", n_beats - s_beats, 8);

    // Zero-length request
    snap();
    start_burst(AW'($urandom), 12'd0);
    step(3);
    check("t4_no_reads", n_reads - s_reads, 0);
    check("t4_done_count", n_done - s_done, 1);
    check("t4_done_cycle", done_cyc - s_cyc, 1);
    check("t4_busy_never", n_busy - s_busy, 0);

    // Random bursts with a mid-burst start that must be ignored
    rand_ready = 1;
    for (int t = 0; t < 4; t++) begin
      int unsigned l;
      l = $urandom_range(8, 40);
      snap();
      start_burst(AW'($urandom), (AW + 1)'(l));
      step(3);
      base_addr = AW'($urandom); len = (AW + 1)'($urandom_range(1, 5)); start = 1'b1;
      step(1);
      start = 1'b0;
      wait_done(2000);
      check("rand_beats", n_beats - s_beats, l);
      check("rand_reads", n_reads - s_reads, l);
      check("rand_done_once", n_done - s_done, 1);
    end

    // Full-memory burst
    for (int i = 0; i < NWORDS; i++) hits_base[i] = rd_hits[i];
    snap();
    start_burst(AW'($urandom), 12'd2048);
    wait_done(20000);
    step(3);
    begin
      int unsigned bad = 0;
      for (int i = 0; i < NWORDS; i++) if (rd_hits[i] - hits_base[i] != 1) bad++;
      check("t5_each_addr_once", bad, 0);
    end
    check("t5_beats", n_beats - s_beats, 2048);
    check("t5_done_once", n_done - s_done, 1);

    // Reset in the middle of a burst, then a short burst
    rand_ready = 0;
    bus.out_ready = 1'b1;
    snap();
    start_burst(11'h100, 12'd16);
    step(4);
    check("t6_busy_before_reset", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_valid", bus.out_valid, 1'b0);
    check("t6_rst_cen", bus.sram_cen, 1'b1);
    check("t6_rst_addr", bus.sram_a, '0);
    step(2);
    reset_n = 1'b1;
    step(6);
    check("t6_no_done_after_reset", n_done - s_done, 0);
    snap();
    start_burst(11'h020, 12'd2);
    wait_done(100);
    check("t6_beats", n_beats - s_beats, 2);
    check("t6_reads", n_reads - s_reads, 2);

    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
